// File: rtl/vga_pkg.sv
// Shared constants, control codes and enums for the VGA text console.
package vga_pkg;
  localparam int COLS = 64;
  localparam int ROWS = 24;
  localparam int XW   = 6;
  localparam int YW   = 5;
  localparam logic [7:0] BLANK_CODE = 8'h20;

  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] BS  = 8'h08;
  localparam logic [7:0] TAB = 8'h09;
  localparam logic [7:0] FF  = 8'h0C;

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ADV  = 3'd1,
    OP_LF   = 3'd2,
    OP_CR   = 3'd3,
    OP_BS   = 3'd4,
    OP_TAB  = 3'd5
  } cursor_op_t;

  function automatic logic is_printable(input logic [7:0] code);
    return ((code >= 8'h20) && (code <= 8'h7E)) || (code >= 8'h80);
  endfunction
endpackage

// File: rtl/vga_console_if.sv
// Byte-stream input and character write port of the VGA console.
interface vga_console_if;
  import vga_pkg::*;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic [23:0]   in_fg;
  logic [23:0]   in_bg;
  logic          charWr;
  logic [23:0]   charWrFgColor;
  logic [23:0]   charWrBgColor;
  logic [7:0]    charWrCode;
  logic [XW-1:0] charWrX;
  logic [YW-1:0] charWrY;

  modport master (
    output in_valid, in_data, in_fg, in_bg,
    input  in_ready, charWr, charWrFgColor, charWrBgColor, charWrCode, charWrX, charWrY
  );

  modport slave (
    input  in_valid, in_data, in_fg, in_bg,
    output in_ready, charWr, charWrFgColor, charWrBgColor, charWrCode, charWrX, charWrY
  );
endinterface

// File: rtl/vga_console_cursor.sv
// Combinational cursor stepper: advance, newline, return, backspace and tab
// with column and row wrap. Also drives the clear sweep in row-major order.
module vga_cursor
  import vga_pkg::*;
#(
  parameter int COLS = vga_pkg::COLS,
  parameter int ROWS = vga_pkg::ROWS
) (
  input  cursor_op_t    op,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [XW-1:0] next_x,
  output logic [YW-1:0] next_y,
  output logic          col_wrap,
  output logic          row_wrap
);
  localparam int TW = XW + 1;

  logic [YW-1:0] y_inc_s;
  logic          y_last_s;
  logic [TW-1:0] tab_s;

  // Next position for the requested operation; no scrolling, rows wrap to 0.
  always_comb begin
    y_last_s = (y == YW'(ROWS - 1));
    y_inc_s  = y_last_s ? {YW{1'b0}} : (y + YW'(1));
    tab_s    = ({1'b0, x} | TW'(7)) + TW'(1);
    next_x   = x;
    next_y   = y;
    col_wrap = 1'b0;
    row_wrap = 1'b0;
    case (op)
      OP_ADV: begin
        if (x == XW'(COLS - 1)) begin
          next_x   = {XW{1'b0}};
          next_y   = y_inc_s;
          col_wrap = 1'b1;
          row_wrap = y_last_s;
        end else begin
          next_x = x + XW'(1);
        end
      end
      OP_LF: begin
        next_x   = {XW{1'b0}};
        next_y   = y_inc_s;
        row_wrap = y_last_s;
      end
      OP_CR: next_x = {XW{1'b0}};
      OP_BS: begin
        if (x != {XW{1'b0}}) begin
          next_x = x - XW'(1);
        end else begin
          next_x = x;
        end
      end
      OP_TAB: begin
        if (int'(tab_s) >= COLS) begin
          next_x   = {XW{1'b0}};
          next_y   = y_inc_s;
          col_wrap = 1'b1;
          row_wrap = y_last_s;
        end else begin
          next_x = tab_s[XW-1:0];
        end
      end
      default: next_x = x;
    endcase
  end
endmodule

// File: rtl/vga_console.sv
// Text console: turns an ASCII byte stream into character-cell writes with
// cursor handling, and sweeps the whole screen with blanks on form feed.
module vga_console
  import vga_pkg::*;
#(
  parameter int         COLS       = vga_pkg::COLS,
  parameter int         ROWS       = vga_pkg::ROWS,
  parameter logic [7:0] BLANK_CODE = vga_pkg::BLANK_CODE
) (
  input  logic          CLOCK_50,
  input  logic          rst_n,
  vga_console_if.slave  bus,
  output logic [XW-1:0] cursorX,
  output logic [YW-1:0] cursorY,
  output logic          busy
);
  state_t        state_r, state_s;
  logic [XW-1:0] cur_x_r, cur_x_s, clr_x_r, clr_x_s, wr_x_r, wr_x_s;
  logic [YW-1:0] cur_y_r, cur_y_s, clr_y_r, clr_y_s, wr_y_r, wr_y_s;
  logic          clr_done_r, clr_done_s, busy_r, busy_s, wr_r, wr_s;
  logic [23:0]   clr_fg_r, clr_fg_s, clr_bg_r, clr_bg_s;
  logic [23:0]   wr_fg_r, wr_fg_s, wr_bg_r, wr_bg_s;
  logic [7:0]    wr_code_r, wr_code_s;
  logic          accept_s;
  cursor_op_t    op_s;
  logic [XW-1:0] op_x_s, nx_s;
  logic [YW-1:0] op_y_s, ny_s;
  logic          col_wrap_s, row_wrap_s;

  assign bus.in_ready      = (state_r == IDLE) && rst_n;
  assign bus.charWr        = wr_r;
  assign bus.charWrCode    = wr_code_r;
  assign bus.charWrX       = wr_x_r;
  assign bus.charWrY       = wr_y_r;
  assign bus.charWrFgColor = wr_fg_r;
  assign bus.charWrBgColor = wr_bg_r;
  assign cursorX           = cur_x_r;
  assign cursorY           = cur_y_r;
  assign busy              = busy_r;

  // The stepper is shared: the sweep counter during CLEAR, the cursor otherwise.
  always_comb begin
    accept_s = bus.in_valid && (state_r == IDLE);
    op_s     = OP_NONE;
    op_x_s   = cur_x_r;
    op_y_s   = cur_y_r;
    if (state_r == CLEAR) begin
      op_s   = OP_ADV;
      op_x_s = clr_x_r;
      op_y_s = clr_y_r;
    end else if (accept_s) begin
      case (bus.in_data)
        LF:      op_s = OP_LF;
        CR:      op_s = OP_CR;
        BS:      op_s = OP_BS;
        TAB:     op_s = OP_TAB;
        default: op_s = is_printable(bus.in_data) ? OP_ADV : OP_NONE;
      endcase
    end else begin
      op_s = OP_NONE;
    end
  end

  vga_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .op       (op_s),
    .x        (op_x_s),
    .y        (op_y_s),
    .next_x   (nx_s),
    .next_y   (ny_s),
    .col_wrap (col_wrap_s),
    .row_wrap (row_wrap_s)
  );

  // Next-state and write decode; CLEAR holds one extra cycle after the last strobe.
  always_comb begin
    state_s    = state_r;
    cur_x_s    = cur_x_r;
    cur_y_s    = cur_y_r;
    clr_x_s    = clr_x_r;
    clr_y_s    = clr_y_r;
    clr_done_s = clr_done_r;
    clr_fg_s   = clr_fg_r;
    clr_bg_s   = clr_bg_r;
    wr_s       = 1'b0;
    wr_code_s  = wr_code_r;
    wr_x_s     = wr_x_r;
    wr_y_s     = wr_y_r;
    wr_fg_s    = wr_fg_r;
    wr_bg_s    = wr_bg_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          cur_x_s = nx_s;
          cur_y_s = ny_s;
          if (is_printable(bus.in_data)) begin
            wr_s      = 1'b1;
            wr_code_s = bus.in_data;
            wr_x_s    = cur_x_r;
            wr_y_s    = cur_y_r;
            wr_fg_s   = bus.in_fg;
            wr_bg_s   = bus.in_bg;
          end else if ((bus.in_data == BS) && (cur_x_r != {XW{1'b0}})) begin
            wr_s      = 1'b1;
            wr_code_s = BLANK_CODE;
            wr_x_s    = nx_s;
            wr_y_s    = ny_s;
            wr_fg_s   = bus.in_fg;
            wr_bg_s   = bus.in_bg;
          end else if (bus.in_data == FF) begin
            state_s    = CLEAR;
            clr_x_s    = {XW{1'b0}};
            clr_y_s    = {YW{1'b0}};
            clr_done_s = 1'b0;
            clr_fg_s   = bus.in_fg;
            clr_bg_s   = bus.in_bg;
          end else begin
            wr_s = 1'b0;
          end
        end else begin
          wr_s = 1'b0;
        end
      end
      CLEAR: begin
        if (clr_done_r) begin
          state_s = IDLE;
          cur_x_s = {XW{1'b0}};
          cur_y_s = {YW{1'b0}};
        end else begin
          wr_s       = 1'b1;
          wr_code_s  = BLANK_CODE;
          wr_x_s     = clr_x_r;
          wr_y_s     = clr_y_r;
          wr_fg_s    = clr_fg_r;
          wr_bg_s    = clr_bg_r;
          clr_x_s    = nx_s;
          clr_y_s    = ny_s;
          clr_done_s = col_wrap_s && row_wrap_s;
        end
      end
      default: state_s = IDLE;
    endcase
    busy_s = (state_s == CLEAR);
  end

  // State, cursor, sweep and registered write-port outputs.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cur_x_r    <= {XW{1'b0}};
      cur_y_r    <= {YW{1'b0}};
      clr_x_r    <= {XW{1'b0}};
      clr_y_r    <= {YW{1'b0}};
      clr_done_r <= 1'b0;
      clr_fg_r   <= 24'h000000;
      clr_bg_r   <= 24'h000000;
      busy_r     <= 1'b0;
      wr_r       <= 1'b0;
      wr_code_r  <= 8'h00;
      wr_x_r     <= {XW{1'b0}};
      wr_y_r     <= {YW{1'b0}};
      wr_fg_r    <= 24'h000000;
      wr_bg_r    <= 24'h000000;
    end else begin
      state_r    <= state_s;
      cur_x_r    <= cur_x_s;
      cur_y_r    <= cur_y_s;
      clr_x_r    <= clr_x_s;
      clr_y_r    <= clr_y_s;
      clr_done_r <= clr_done_s;
      clr_fg_r   <= clr_fg_s;
      clr_bg_r   <= clr_bg_s;
      busy_r     <= busy_s;
      wr_r       <= wr_s;
      wr_code_r  <= wr_code_s;
      wr_x_r     <= wr_x_s;
      wr_y_r     <= wr_y_s;
      wr_fg_r    <= wr_fg_s;
      wr_bg_r    <= wr_bg_s;
    end
  end
endmodule

// File: doc/vga_console.md
VGA_CONSOLE -- requirements
Module: vga_console

Interface
REQ-001 Parameter COLS, default 64, text columns; SHALL match the 6-bit column address.
REQ-002 Parameter ROWS, default 24, text rows (480/20); SHALL fit the 5-bit row address.
REQ-003 Parameter BLANK_CODE, default 8'h20, character code written by clear and backspace.
REQ-004 CLOCK_50  in  1  sole clock; SHALL be the same clock as the display's write port.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  byte available on in_data.
REQ-007 in_ready  out  1  block can accept a byte this cycle.
REQ-008 in_data  in  8  ASCII byte.
REQ-009 in_fg  in  24  foreground RGB, sampled with the byte.
REQ-010 in_bg  in  24  background RGB, sampled with the byte.
REQ-011 charWr  out  1  one-cycle character write strobe.
REQ-012 charWrFgColor, charWrBgColor  out  24 each  colors for the write.
REQ-013 charWrCode  out  8  glyph code.
REQ-014 charWrX  out  6 / charWrY  out  5  cell address.
REQ-015 cursorX  out  6 / cursorY  out  5  current cursor position.
REQ-016 busy  out  1  high while a clear sweep runs.

Function
REQ-017 Byte accepted only on a cycle with in_valid && in_ready; in_ready SHALL be 1 exactly when state == IDLE and rst_n is high.
REQ-018 States: IDLE, CLEAR; IDLE sustains one accepted byte per cycle.
REQ-019 All charWr* outputs registered; the write for an accepted byte SHALL appear exactly 1 cycle after acceptance, as a single-cycle pulse.
REQ-020 Printable (0x20-0x7E, 0x80-0xFF): write code at (cursorX,cursorY) with the sampled colors; then cursorX+1.
REQ-021 Column wrap: when cursorX == COLS-1, the advance SHALL set cursorX=0 and cursorY+1.
REQ-022 Row wrap: when cursorY == ROWS-1, cursorY+1 SHALL yield 0; there is no scrolling.
REQ-023 0x0A (LF): cursorX=0, cursorY+1 with the row wrap; no write.
REQ-024 0x0D (CR): cursorX=0; no write.
REQ-025 0x08 (BS): if cursorX>0, cursorX-1 and write BLANK_CODE at the new position; at cursorX==0, no change and no write.
REQ-026 0x09 (TAB): cursorX set to the next multiple of 8; reaching COLS wraps as in REQ-021; no write.
REQ-027 0x0C (FF): enter CLEAR; latch the sampled colors.
REQ-028 All other codes (0x00-0x1F not listed above, and 0x7F) SHALL be ignored: no write, no cursor change.
REQ-029 CLEAR: write BLANK_CODE to every cell, one per cycle, row-major from (0,0) to (COLS-1,ROWS-1), COLS*ROWS strobes total (1536 by default).
REQ-030 CLEAR: busy=1 and in_ready=0 for the whole sweep.
REQ-031 The cycle after the final strobe: cursor=(0,0), busy=0, state IDLE.
REQ-032 The sweep counter SHALL never emit a row >= ROWS.
REQ-033 cursorX/cursorY SHALL update in the same cycle the corresponding write is emitted.

Reset
REQ-034 rst_n low SHALL asynchronously force IDLE, cursor (0,0), busy=0, charWr=0 and all charWr* data outputs to 0.
REQ-035 Reset during CLEAR SHALL abort the sweep with no further strobes.
REQ-036 The first byte may be accepted on the first CLOCK_50 edge after rst_n deasserts.

Structure
REQ-037 A shared package vga_pkg SHALL hold COLS, ROWS, BLANK_CODE, the control-code constants (LF, CR, BS, TAB, FF) and the state enum.
REQ-038 Cursor advance/wrap logic SHALL be a sub-module vga_cursor (inputs: op and current X/Y; outputs: next X/Y and wrap flags).

Verification
REQ-039 After reset, send 'A' (0x41) with fg 0xFFFFFF and bg 0x000000 -> 1 cycle later charWr=1, code 0x41, X=0, Y=0; cursor becomes (1,0).
REQ-040 Send 64 consecutive 'B' with in_valid held high -> 64 strobes on consecutive cycles at X 0..63, Y=0; final cursor (0,1).
REQ-041 Cursor at (63,23), send 'C' -> write at (63,23); cursor becomes (0,0).
REQ-042 Cursor (5,3), send BS -> write 0x20 at (4,3), cursor (4,3); then CR -> cursor (0,3), no strobe; then BS -> no strobe, cursor (0,3).
REQ-043 Send FF with bg 0x0000FF -> in_ready low; exactly 1536 strobes of 0x20 with bg 0x0000FF, ordered (0,0)..(63,23); then busy=0, cursor (0,0).
REQ-044 Assert rst_n low at strobe 700 of a clear -> no further strobes; all outputs 0; in_ready=1 on the first edge after release.
